hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- load-use stall / taken-branch flush controller with
// EX/MEM/WB destination tracking for a 5-stage pipeline.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID instruction is real (not a bubble)
//   id_rn, id_rm, id_rd        ID sources A/B and destination register
//   id_uses_rm                 ID instruction reads id_rm
//   id_regwr, id_memread       ID instruction writes regfile / is a load
//   br_taken_ex                EX branch resolved taken this cycle
//   dest_ex/mem/wb             registered destination per stage
//   regwr_ex/mem/wb            registered regfile write enable per stage
//   memread_ex                 registered load flag of EX
//   pc_we, ifid_we             PC / IF-ID write enables (combinational)
//   idex_bubble, ifid_flush    NOP into ID/EX / clear IF/ID next edge
//   stall_cnt, flush_cnt       saturating event counters (CNT_W bits)
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rm,
    input  logic             id_regwr,
    input  logic             id_memread,
    input  logic             br_taken_ex,
    output logic [4:0]       dest_ex,
    output logic [4:0]       dest_mem,
    output logic [4:0]       dest_wb,
    output logic             regwr_ex,
    output logic             regwr_mem,
    output logic             regwr_wb,
    output logic             memread_ex,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic       memread;
        logic [4:0] dest;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, regwr: 1'b0, memread: 1'b0, dest: XZR};

    stage_t ex_q, mem_q, wb_q, ex_d;
    logic   lu, br, stall;
    logic [CNT_W-1:0] stall_q, flush_q;

    // Write enables are qualified by the valid bit so a bubble can never
    // produce a regfile write, whatever its other fields hold.
    assign dest_ex    = ex_q.dest;
    assign dest_mem   = mem_q.dest;
    assign dest_wb    = wb_q.dest;
    assign regwr_ex   = ex_q.valid & ex_q.regwr;
    assign regwr_mem  = mem_q.valid & mem_q.regwr;
    assign regwr_wb   = wb_q.valid & wb_q.regwr;
    assign memread_ex = ex_q.valid & ex_q.memread;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;

    // XZR is excluded as a producer, which also covers XZR as a source:
    // a source of 31 can only match a destination of 31.
    always_comb begin
        lu = memread_ex & regwr_ex & (dest_ex != XZR) & id_valid &
             ((id_rn == dest_ex) | (id_uses_rm & (id_rm == dest_ex)));
        // Gating with rst_n keeps the control outputs at their idle values
        // for the whole reset window, even if br_taken_ex is floating high.
        br    = rst_n & br_taken_ex;
        // A taken branch squashes the stalled instruction, so it wins.
        stall = rst_n & lu & ~br;

        pc_we       = ~stall;
        ifid_we     = ~stall;
        idex_bubble = br | stall;
        ifid_flush  = br;

        ex_d = BUBBLE;
        if (!idex_bubble && id_valid) begin
            ex_d.valid   = 1'b1;
            ex_d.regwr   = id_regwr;
            ex_d.memread = id_memread;
            ex_d.dest    = id_rd;
        end
    end

    // EX/MEM/WB always advance; a stall only holds PC and IF/ID upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (br && (flush_q != '1))    flush_q <= flush_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rm, id_regwr, id_memread, br_taken_ex;
    logic [4:0]  id_rn, id_rm, id_rd;

    logic [4:0]  dest_ex, dest_mem, dest_wb;
    logic        regwr_ex, regwr_mem, regwr_wb, memread_ex;
    logic        pc_we, ifid_we, idex_bubble, ifid_flush;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter instance on the same stimulus: saturation is reached
    // within the random run instead of after 65535 stalls.
    logic [4:0]  s_dest_ex, s_dest_mem, s_dest_wb;
    logic        s_regwr_ex, s_regwr_mem, s_regwr_wb, s_memread_ex;
    logic        s_pc_we, s_ifid_we, s_idex_bubble, s_ifid_flush;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_uses_rm(id_uses_rm), .id_regwr(id_regwr), .id_memread(id_memread),
        .br_taken_ex(br_taken_ex), .dest_ex(dest_ex), .dest_mem(dest_mem), .dest_wb(dest_wb),
        .regwr_ex(regwr_ex), .regwr_mem(regwr_mem), .regwr_wb(regwr_wb), .memread_ex(memread_ex),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_uses_rm(id_uses_rm), .id_regwr(id_regwr), .id_memread(id_memread),
        .br_taken_ex(br_taken_ex), .dest_ex(s_dest_ex), .dest_mem(s_dest_mem), .dest_wb(s_dest_wb),
        .regwr_ex(s_regwr_ex), .regwr_mem(s_regwr_mem), .regwr_wb(s_regwr_wb),
        .memread_ex(s_memread_ex), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
        .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Reference model: the three in-flight instructions as plain records,
    // index 0 = EX, 1 = MEM, 2 = WB; counters kept as unbounded totals.
    typedef struct {
        bit real_instr;
        bit writes;
        bit is_load;
        int rd;
    } instr_t;

    instr_t pipe [3];
    int     n_stalls, n_flushes;

    function automatic instr_t nop();
        instr_t n;
        n.real_instr = 0; n.writes = 0; n.is_load = 0; n.rd = 31;
        return n;
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        n_stalls  = 0;
        n_flushes = 0;
    endtask

    // A load in EX whose (non-XZR) target is read by a real ID instruction.
    function automatic bit model_load_use();
        instr_t p;
        p = pipe[0];
        if (!rst_n || !id_valid || !p.is_load || !p.writes || p.rd == 31) return 0;
        return (int'(id_rn) == p.rd) || (id_uses_rm && int'(id_rm) == p.rd);
    endfunction

    function automatic bit model_branch();
        return rst_n && br_taken_ex;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit br, st;
        br = model_branch();
        st = model_load_use() && !br;
        chk("pc_we",       pc_we,       !st);
        chk("ifid_we",     ifid_we,     !st);
        chk("idex_bubble", idex_bubble, br || st);
        chk("ifid_flush",  ifid_flush,  br);
        chk("dest_ex",     dest_ex,     pipe[0].rd);
        chk("dest_mem",    dest_mem,    pipe[1].rd);
        chk("dest_wb",     dest_wb,     pipe[2].rd);
        chk("regwr_ex",    regwr_ex,    pipe[0].writes);
        chk("regwr_mem",   regwr_mem,   pipe[1].writes);
        chk("regwr_wb",    regwr_wb,    pipe[2].writes);
        chk("memread_ex",  memread_ex,  pipe[0].is_load);
        chk("stall_cnt",   stall_cnt,   sat(n_stalls, 65535));
        chk("flush_cnt",   flush_cnt,   sat(n_flushes, 65535));
        chk("sat_stall_cnt", s_stall_cnt, sat(n_stalls, 15));
        chk("sat_flush_cnt", s_flush_cnt, sat(n_flushes, 15));
        chk("sat_pc_we",   s_pc_we,     !st);
    endtask

    // Clock edge: advance the model with the inputs held across the edge.
    task automatic tick();
        bit br, st;
        instr_t id;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            br = model_branch();
            st = model_load_use() && !br;
            if (st) n_stalls++;
            if (br) n_flushes++;
            id = nop();
            if (id_valid && !br && !st) begin
                id.real_instr = 1; id.writes = id_regwr; id.is_load = id_memread; id.rd = id_rd;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = id;
        end
        @(negedge clk);
    endtask

    // Apply ID/EX inputs in the low phase, then compare once they settle.
    task automatic drive(bit v, int rn, int rm, int rd, bit urm, bit rw, bit mr, bit br);
        id_valid = v; id_rn = 5'(rn); id_rm = 5'(rm); id_rd = 5'(rd);
        id_uses_rm = urm; id_regwr = rw; id_memread = mr; br_taken_ex = br;
        #1;
        compare();
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 4))
            0: return 3;
            1: return 5;
            2: return 7;
            3: return 31;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, with a stray branch-taken that must be ignored
        drive(1, 5, 5, 5, 1, 1, 1, 1);
        chk("rst pc_we", pc_we, 1);
        chk("rst ifid_flush", ifid_flush, 0);
        chk("rst idex_bubble", idex_bubble, 0);
        chk("rst dest_wb", dest_wb, 31);
        tick();
        chk("rst dest_ex held", dest_ex, 31);
        chk("rst stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        // Branch overrides a load-use stall
        drive(1, 0, 0, 5, 0, 1, 1, 0);
        tick();
        drive(1, 5, 0, 9, 0, 1, 0, 1);
        chk("br ifid_flush", ifid_flush, 1);
        chk("br idex_bubble", idex_bubble, 1);
        chk("br pc_we", pc_we, 1);
        tick();
        chk("br flush_cnt", flush_cnt, 1);
        chk("br stall_cnt", stall_cnt, 0);

        // Basic load-use stall on rn
        drive(1, 0, 0, 5, 0, 1, 1, 0);
        tick();
        drive(1, 5, 0, 9, 0, 1, 0, 0);
        chk("lu pc_we", pc_we, 0);
        chk("lu ifid_we", ifid_we, 0);
        chk("lu idex_bubble", idex_bubble, 1);
        tick();
        chk("lu regwr_ex", regwr_ex, 0);
        chk("lu dest_mem", dest_mem, 5);
        chk("lu stall_cnt", stall_cnt, 1);
        drive(1, 5, 0, 9, 0, 1, 0, 0);
        chk("lu released", pc_we, 1);
        tick();

        // XZR load never stalls
        drive(1, 0, 0, 31, 0, 1, 1, 0);
        tick();
        drive(1, 31, 0, 2, 0, 1, 0, 0);
        chk("xzr pc_we", pc_we, 1);
        tick();
        chk("xzr stall_cnt", stall_cnt, 1);

        // rm only counts when it is read
        drive(1, 0, 0, 7, 0, 1, 1, 0);
        tick();
        drive(1, 1, 7, 2, 0, 1, 0, 0);
        chk("rm unused pc_we", pc_we, 1);
        drive(1, 1, 7, 2, 1, 1, 0, 0);
        chk("rm used pc_we", pc_we, 0);
        tick();
        chk("rm stall_cnt", stall_cnt, 2);

        // Back-to-back writers X3, X4
        drive(1, 0, 0, 3, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 4, 0, 1, 0, 0);
        tick();
        chk("b2b dest_ex", dest_ex, 4);
        chk("b2b dest_mem", dest_mem, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("b2b dest_ex2", dest_ex, 31);
        chk("b2b dest_mem2", dest_mem, 4);
        chk("b2b dest_wb2", dest_wb, 3);
        chk("b2b regwr_wb", regwr_wb, 1);
        chk("b2b regwr_ex", regwr_ex, 0);

        // Reset asserted in the middle of a stall cycle
        drive(1, 0, 0, 5, 0, 1, 1, 0);
        tick();
        drive(1, 5, 0, 9, 0, 1, 0, 0);
        chk("mid stall pc_we", pc_we, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        chk("async pc_we", pc_we, 1);
        chk("async memread_ex", memread_ex, 0);
        chk("async dest_ex", dest_ex, 31);
        chk("async stall_cnt", stall_cnt, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 5, 0, 9, 0, 1, 0, 0);
        chk("post rst no hazard", pc_we, 1);
        tick();

        // Randomized run against the model; load-heavy to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 7) != 0, pick_reg(), pick_reg(), pick_reg(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
